// File: rtl/morra_pkg.sv
// Shared codes and state encoding for the MorraCinese scoreboard.
package morra_pkg;

    localparam logic [1:0] NON_VALIDA = 2'b00;
    localparam logic [1:0] G1         = 2'b01;
    localparam logic [1:0] G2         = 2'b10;
    localparam logic [1:0] PARI       = 2'b11;

    typedef enum logic [1:0] {
        StAttesa       = 2'b00,
        StInGioco      = 2'b01,
        StChiusa       = 2'b10,
        StTorneoChiuso = 2'b11
    } stato_e;

endpackage

// File: rtl/contatore_sat.sv
// CW-bit saturating counter with synchronous clear (priority) and increment enable.
module contatore_sat #(
    parameter int unsigned CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/morra_tabellone.sv
// Scoreboard downstream of the MorraCinese game: per-match round stats and best-of-N tournament.
module morra_tabellone
    import morra_pkg::*;
#(
    parameter int unsigned N_PARTITE = 3,
    parameter int unsigned CW        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          INIZIA,
    input  logic [1:0]    MANCHE,
    input  logic [1:0]    PARTITA,
    input  logic          NUOVO_TORNEO,
    output logic [CW-1:0] VITTORIE_G1,
    output logic [CW-1:0] VITTORIE_G2,
    output logic [CW-1:0] PAREGGI,
    output logic [CW-1:0] NON_VALIDE,
    output logic [CW-1:0] PARTITE_G1,
    output logic [CW-1:0] PARTITE_G2,
    output logic [CW-1:0] PARTITE_GIOCATE,
    output logic [1:0]    TORNEO,
    output logic          FINE_PARTITA,
    output logic          FINE_TORNEO
);

    localparam logic [CW-1:0] WinTh   = CW'(N_PARTITE / 2 + 1);
    localparam logic [CW-1:0] NPartite = CW'(N_PARTITE);

    stato_e     stato_q;
    logic       inizia_q;
    logic [1:0] torneo_q;
    logic       fine_partita_q;
    logic       fine_torneo_q;

    logic       conta;
    logic       chiude;
    logic       clr_partita;
    logic       inc_pg1;
    logic       inc_pg2;
    logic       decide;
    logic [1:0] esito;
    logic [CW-1:0] pg1_post;
    logic [CW-1:0] pg2_post;
    logic [CW-1:0] giocate_post;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CW'(1) : v;
    endfunction

    // Rounds count only in a live match cycle not pre-empted by a restart or clear.
    assign conta       = (stato_q == StInGioco) && !inizia_q && !NUOVO_TORNEO;
    assign chiude      = conta && (PARTITA != NON_VALIDA);
    assign clr_partita = NUOVO_TORNEO || (inizia_q && (stato_q != StTorneoChiuso));
    assign inc_pg1     = chiude && (PARTITA == G1);
    assign inc_pg2     = chiude && (PARTITA == G2);

    assign pg1_post     = sat_inc(PARTITE_G1, inc_pg1);
    assign pg2_post     = sat_inc(PARTITE_G2, inc_pg2);
    assign giocate_post = sat_inc(PARTITE_GIOCATE, chiude);

    always_comb begin
        decide = 1'b0;
        esito  = NON_VALIDA;
        if (pg1_post >= WinTh) begin
            decide = 1'b1;
            esito  = G1;
        end else if (pg2_post >= WinTh) begin
            decide = 1'b1;
            esito  = G2;
        end else if (giocate_post == NPartite) begin
            decide = 1'b1;
            if (pg1_post > pg2_post)      esito = G1;
            else if (pg2_post > pg1_post) esito = G2;
            else                          esito = PARI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stato_q        <= StAttesa;
            inizia_q       <= 1'b0;
            torneo_q       <= NON_VALIDA;
            fine_partita_q <= 1'b0;
            fine_torneo_q  <= 1'b0;
        end else begin
            inizia_q       <= INIZIA;
            fine_partita_q <= 1'b0;
            fine_torneo_q  <= 1'b0;
            if (NUOVO_TORNEO) begin
                torneo_q <= NON_VALIDA;
                stato_q  <= inizia_q ? StInGioco : StAttesa;
            end else if (inizia_q && (stato_q != StTorneoChiuso)) begin
                stato_q <= StInGioco;
            end else if (chiude) begin
                fine_partita_q <= 1'b1;
                if (decide) begin
                    fine_torneo_q <= 1'b1;
                    torneo_q      <= esito;
                    stato_q       <= StTorneoChiuso;
                end else begin
                    stato_q <= StChiusa;
                end
            end
        end
    end

    contatore_sat #(.CW(CW)) u_vittorie_g1 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr_partita),
        .inc_i(conta && (MANCHE == G1)), .cnt_o(VITTORIE_G1)
    );
    contatore_sat #(.CW(CW)) u_vittorie_g2 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr_partita),
        .inc_i(conta && (MANCHE == G2)), .cnt_o(VITTORIE_G2)
    );
    contatore_sat #(.CW(CW)) u_pareggi (
        .clk_i(clk), .rst_i(rst), .clr_i(clr_partita),
        .inc_i(conta && (MANCHE == PARI)), .cnt_o(PAREGGI)
    );
    contatore_sat #(.CW(CW)) u_non_valide (
        .clk_i(clk), .rst_i(rst), .clr_i(clr_partita),
        .inc_i(conta && (MANCHE == NON_VALIDA)), .cnt_o(NON_VALIDE)
    );
    contatore_sat #(.CW(CW)) u_partite_g1 (
        .clk_i(clk), .rst_i(rst), .clr_i(NUOVO_TORNEO),
        .inc_i(inc_pg1), .cnt_o(PARTITE_G1)
    );
    contatore_sat #(.CW(CW)) u_partite_g2 (
        .clk_i(clk), .rst_i(rst), .clr_i(NUOVO_TORNEO),
        .inc_i(inc_pg2), .cnt_o(PARTITE_G2)
    );
    contatore_sat #(.CW(CW)) u_partite_giocate (
        .clk_i(clk), .rst_i(rst), .clr_i(NUOVO_TORNEO),
        .inc_i(chiude), .cnt_o(PARTITE_GIOCATE)
    );

    assign TORNEO       = torneo_q;
    assign FINE_PARTITA = fine_partita_q;
    assign FINE_TORNEO  = fine_torneo_q;

endmodule

// File: doc/morra_tabellone.md
Name: morra_tabellone

Overview:
- Scoreboard stage directly downstream of the MorraCinese game FSMD.
- Consumes the game's per-round result (MANCHE) and per-match result (PARTITA).
- Keeps per-match round statistics and runs a best-of-N tournament across consecutive matches.
- Drives score outputs and end-of-match / end-of-tournament pulses to the display/host logic.

Parameters:
- N_PARTITE, 3: matches in a tournament; odd, 1..15.
- CW, 4: width of all counters; all counters saturate at 2^CW-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- INIZIA  in  1  same start signal that drives the game.
- MANCHE  in  2  round result: 00 invalid, 01 G1 wins, 10 G2 wins, 11 draw.
- PARTITA  in  2  match result: 00 in progress, 01 G1, 10 G2, 11 draw.
- NUOVO_TORNEO  in  1  one-cycle request to clear the tournament.
- VITTORIE_G1  out  CW  rounds won by G1, current match.
- VITTORIE_G2  out  CW  rounds won by G2, current match.
- PAREGGI  out  CW  drawn rounds, current match.
- NON_VALIDE  out  CW  invalid rounds, current match.
- PARTITE_G1  out  CW  matches won by G1, this tournament.
- PARTITE_G2  out  CW  matches won by G2, this tournament.
- PARTITE_GIOCATE  out  CW  matches closed, this tournament.
- TORNEO  out  2  00 running, 01 G1, 10 G2, 11 draw.
- FINE_PARTITA  out  1  one-cycle pulse when a match closes.
- FINE_TORNEO  out  1  one-cycle pulse when the tournament closes.

Behaviour:
- Reset: synchronous, active-high. Every output and counter goes to 0, TORNEO=00, state=ATTESA, inizia_q=0.
- Alignment:
  - MANCHE and PARTITA are registered game outputs, valid one cycle after their move.
  - INIZIA is delayed one register (inizia_q) so that it aligns with the game's start response.
  - In a cycle with inizia_q=1, MANCHE and PARTITA are ignored.
- States:
  - ATTESA: waiting for a match start.
  - IN_GIOCO: match running.
  - CHIUSA: match closed.
  - TORNEO_CHIUSO: tournament decided.
- Transitions (priority top-down):
  - NUOVO_TORNEO=1 in any state: clear PARTITE_*, PARTITE_GIOCATE, per-match counters and TORNEO; go to ATTESA.
  - If inizia_q=1 in the same cycle, the start also takes effect: go to IN_GIOCO.
  - inizia_q=1 in ATTESA, IN_GIOCO or CHIUSA: clear the four per-match counters and go to IN_GIOCO.
  - A restart from IN_GIOCO abandons the match: nothing is recorded and PARTITE_GIOCATE is unchanged.
  - inizia_q=1 in TORNEO_CHIUSO: ignored; stay.
  - IN_GIOCO, per cycle: increment the counter selected by MANCHE (00→NON_VALIDE, 01→VITTORIE_G1, 10→VITTORIE_G2, 11→PAREGGI).
  - IN_GIOCO with PARTITA≠00: that cycle's MANCHE is still counted. Also:
    - PARTITE_GIOCATE +1;
    - PARTITE_G1 +1 if PARTITA=01, PARTITE_G2 +1 if PARTITA=10, neither if 11;
    - assert FINE_PARTITA for that cycle;
    - go to CHIUSA.
  - CHIUSA: MANCHE/PARTITA ignored, so a held non-zero PARTITA counts once. Per-match counters hold for display.
- Tournament decision, same cycle as the match close, using the post-increment values (WIN_TH = N_PARTITE/2+1):
  - PARTITE_G1 reaches WIN_TH → TORNEO=01.
  - Else PARTITE_G2 reaches WIN_TH → TORNEO=10.
  - Else PARTITE_GIOCATE = N_PARTITE → TORNEO = 01 if G1>G2, 10 if G2>G1, 11 if equal.
  - On a decision: FINE_TORNEO pulses in the same cycle as FINE_PARTITA, and next state is TORNEO_CHIUSO instead of CHIUSA.
- TORNEO_CHIUSO: all counters and TORNEO hold until NUOVO_TORNEO or rst.
- Saturation: each counter stops at 2^CW-1; no wrap.
- Latency: counters and pulses update on the clock edge after MANCHE/PARTITA are presented.

Decomposition:
- Shared package morra_pkg:
  - codes for MANCHE/PARTITA/TORNEO (NON_VALIDA=00, G1=01, G2=10, PARI=11);
  - state enum for ATTESA/IN_GIOCO/CHIUSA/TORNEO_CHIUSO.
- Sub-module contatore_sat: CW-bit saturating counter with synchronous clear and increment enable. Instantiated seven times.
- FSM and decision logic live in morra_tabellone.

Test Plan:
- rst held 2 cycles mid-activity → all outputs 0, TORNEO=00, no pulses, next INIZIA accepted.
- Start, then MANCHE 10,00,11,10,11 with PARTITA=10 on the last → VITTORIE_G2=2, PAREGGI=2, NON_VALIDE=1, VITTORIE_G1=0; FINE_PARTITA single pulse; PARTITE_G2=1, PARTITE_GIOCATE=1; PARTITA held 10 for 3 more cycles → no further change.
- N_PARTITE=3: two matches ending PARTITA=01 → after the second, PARTITE_G1=2, TORNEO=01, FINE_TORNEO coincident with FINE_PARTITA. A third INIZIA plus match → all values unchanged.
- Matches ending 01, 10, 11 → after the third, PARTITE_GIOCATE=3, TORNEO=11, FINE_TORNEO pulse.
- INIZIA after 3 counted rounds (VITTORIE_G1=3) → per-match counters 0, PARTITE_GIOCATE unchanged. NUOVO_TORNEO together with INIZIA → tournament cleared and state IN_GIOCO.
- 17 consecutive MANCHE=11 with PARTITA=00 → PAREGGI=15 and stays 15.
